// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped frequency-sweep scheduler feeding a DDS accumulator's inc_in/sync_i.
// Single, sawtooth-repeat and triangle sweeps with a per-step dwell; config is shadowed at start.
module dds_sweep_ctrl #(
    parameter int INC_BITS   = 32,
    parameter int DWELL_BITS = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [INC_BITS-1:0]   cfg_start_inc,
    input  logic [INC_BITS-1:0]   cfg_stop_inc,
    input  logic [INC_BITS-1:0]   cfg_step,
    input  logic [DWELL_BITS-1:0] cfg_dwell,
    input  logic [1:0]            cfg_mode,
    output logic [INC_BITS-1:0]   inc_out,
    output logic                  sync_o,
    output logic                  busy,
    output logic                  done,
    output logic                  dir_o
);
    typedef enum logic [2:0] {IDLE, SYNC, DWELL, STEP, FINISH} state_t;
    state_t state, state_n;
    logic [DWELL_BITS-1:0] cnt, cnt_n, s_dm1, cfg_dm1;
    logic [INC_BITS-1:0] s_start, s_stop, s_step, tgt, tgt_n, inc_n, nxt;
    logic [1:0] s_mode;
    logic [INC_BITS:0] up, dn;
    logic sync_n, busy_n, done_n, dir_n, load, tri_m;
    // dwell is stored as remaining-cycles-minus-one so a dwell of 0 behaves as 1
    assign cfg_dm1 = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_BITS'(1);
    assign tri_m = (s_mode == 2'd2);
    assign up = {1'b0, inc_out} + {1'b0, s_step};
    assign dn = {1'b0, inc_out} - {1'b0, s_step};
    // carry/borrow or overshoot past the current target clamps onto it
    assign nxt = (s_step == '0) ? tgt :
                 dir_o ? ((up[INC_BITS] || up[INC_BITS-1:0] > tgt) ? tgt : up[INC_BITS-1:0]) :
                         ((dn[INC_BITS] || dn[INC_BITS-1:0] < tgt) ? tgt : dn[INC_BITS-1:0]);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        inc_n = inc_out;
        tgt_n = tgt;
        dir_n = dir_o;
        sync_n = 1'b0;
        done_n = 1'b0;
        busy_n = busy;
        load = 1'b0;
        if (abort) begin
            state_n = IDLE;
            busy_n = 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    state_n = IDLE;
                    if (start) begin
                        load = 1'b1;
                        state_n = SYNC;
                        inc_n = cfg_start_inc;
                        tgt_n = cfg_stop_inc;
                        dir_n = cfg_stop_inc >= cfg_start_inc;
                        cnt_n = cfg_dm1;
                        sync_n = 1'b1;
                        busy_n = 1'b1;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_BITS'(1);
                        state_n = DWELL;
                    end else if (inc_out != tgt) begin
                        inc_n = nxt;
                        cnt_n = s_dm1;
                        state_n = STEP;
                        // triangle turns around on arrival so the endpoint is held only once
                        if (tri_m && nxt == tgt) begin
                            dir_n = ~dir_o;
                            tgt_n = (tgt == s_stop) ? s_start : s_stop;
                        end
                    end else if (s_mode == 2'd1) begin
                        inc_n = s_start;
                        cnt_n = s_dm1;
                        sync_n = 1'b1;
                        state_n = SYNC;
                    end else if (tri_m) begin
                        dir_n = ~dir_o;
                        cnt_n = s_dm1;
                        state_n = STEP;
                    end else begin
                        done_n = 1'b1;
                        busy_n = 1'b0;
                        state_n = FINISH;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            inc_out <= '0;
            tgt <= '0;
            dir_o <= 1'b0;
            sync_o <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
            s_start <= '0;
            s_stop <= '0;
            s_step <= '0;
            s_dm1 <= '0;
            s_mode <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            inc_out <= inc_n;
            tgt <= tgt_n;
            dir_o <= dir_n;
            sync_o <= sync_n;
            done <= done_n;
            busy <= busy_n;
            if (load) begin
                s_start <= cfg_start_inc;
                s_stop <= cfg_stop_inc;
                s_step <= cfg_step;
                s_dm1 <= cfg_dm1;
                s_mode <= cfg_mode;
            end
        end
    end
endmodule
